complex_accum_dump: RTL and testbench
=====================================

// Module: complex_accum_dump
// PURPOSE
//  Integrate-and-dump stage directly downstream of complex_multiplier: sums ACC_LEN
//  consecutive signed complex products (real/imag), then rounds, shifts, saturates
//  and presents one result per block on a valid/ready output.
//  Forms the correlator/despreader back end after the multiplier.
// PARAMETERS
//  IN_W     35  width of signed two's-complement input real/imag
//  ACC_LEN  16  products per dump, >=2 (counter wraps ACC_LEN-1 -> 0)
//  SHIFT    4   arithmetic right shift applied to sum, 0..ACC_W-1
//  OUT_W    32  width of signed output real/imag
//  derived: ACC_W = IN_W + $clog2(ACC_LEN) (no internal overflow possible)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  clear      in   1      sync: abandon partial block (acc, count -> 0)
//  in_valid   in   1      input product valid
//  in_ready   out  1      stage can accept a product this cycle
//  in_real    in   IN_W   signed product real part
//  in_imag    in   IN_W   signed product imag part
//  out_valid  out  1      dumped result valid
//  out_ready  in   1      consumer accepts result
//  out_real   out  OUT_W  signed result real part
//  out_imag   out  OUT_W  signed result imag part
//  sat_flag   out  1      sticky: some dump saturated (cleared by rst only)
// BEHAVIOUR
//  - Reset: acc_real/imag=0, count=0, out_valid=0, out_real/imag=0, sat_flag=0.
//  - Accept = in_valid & in_ready. On accept with count<ACC_LEN-1:
//    acc += in (sign-extended to ACC_W), count++.
//  - On accept with count==ACC_LEN-1 (dump): sum = acc + in; acc <= 0; count <= 0;
//    result loaded into output regs on same edge; out_valid=1 next cycle.
//    Latency: result visible 1 cycle after last sample accepted.
//  - Result per component: r = (sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT
//    (round half toward +inf); if r > 2^(OUT_W-1)-1 -> max, r < -2^(OUT_W-1) -> min;
//    any clip sets sat_flag.
//  - Output hold: out_real/imag/out_valid stable while out_valid & !out_ready.
//    out_valid & out_ready with no dump -> out_valid=0 next cycle.
//  - Backpressure: in_ready = !clear & !(count==ACC_LEN-1 & out_valid & !out_ready).
//    Non-final samples always accepted; no result is ever dropped or overwritten.
//  - Same-cycle dump and out handshake: new result loaded, out_valid stays 1.
//  - clear: acc,count -> 0 next edge; in_ready=0 so concurrent sample not taken;
//    held output and sat_flag unaffected.
//  - rst mid-block or mid-handshake: all state to reset values immediately
//    (async), pending result discarded.
//  - in_valid low: acc/count hold; gaps between samples are allowed.
// TESTING (ACC_LEN=4, SHIFT=2, OUT_W=32, IN_W=35 unless stated)
//  1 4x (re=+8, im=-8), out_ready=1 -> one cycle after 4th: out=(8,-8), valid 1 cycle.
//  2 re=1,1,1,3 then re=-1,-1,-1,-3 -> out_real=2 then -1 (round-half-up check).
//  3 OUT_W=8: 4x re=2^30 -> out_real=127, sat_flag=1 stays after later small block.
//  4 out_ready=0, feed 8 samples (2 blocks) -> 3 more accepted, in_ready=0 on 8th
//    until out_ready=1; both results (+4, +8 for re=4,4,4,4 / 8,8,8,8) delivered in order.
//  5 2 samples re=100, clear, 4x re=4 -> out_real=4 (partial block discarded).
//  6 rst asserted after 3 samples with out_valid=1 -> all outputs 0 at once;
//    next 4x re=4 -> out_real=4.

Source files
------------

// File: rtl/complex_accum_dump.sv
// complex_accum_dump: integrate-and-dump for complex products.
// Sums ACC_LEN signed products per lane (real, imag). On the last sample of a
// block the sum is rounded half toward +inf, arithmetically shifted, saturated
// to OUT_W bits and presented on a valid/ready output. The result is held until
// the consumer takes it, and the final sample of the next block is refused
// while the output slot is still occupied.

// One lane: accumulator plus round/shift/saturate of the would-be sum.
module complex_accum_dump_lane #(
    parameter int IN_W  = 35,
    parameter int ACC_W = 39,
    parameter int SHIFT = 4,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic             last,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] res,
    output logic             sat
);
    // Working width: one bit of headroom for the rounding add, and never
    // narrower than the output so the clip compare is always meaningful.
    localparam int RW = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W + 1;
    localparam logic [RW-1:0] RND    = (RW'(1) << SHIFT) >> 1;
    localparam logic [RW-1:0] MAX_V  = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [RW-1:0] MIN_V  = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    shf;
    logic                    hi;
    logic                    lo;

    assign sum = acc + ACC_W'($signed(din));
    assign rnd = RW'(sum) + $signed(RND);
    assign shf = rnd >>> SHIFT;
    assign hi  = shf > $signed(MAX_V);
    assign lo  = shf < $signed(MIN_V);
    assign sat = hi | lo;
    assign res = hi ? MAX_O : (lo ? MIN_O : shf[OUT_W-1:0]);

    // Accumulate accepted samples; restart after a dump or a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear || (accept && last)) begin
            acc <= '0;
        end else if (accept) begin
            acc <= sum;
        end
    end
endmodule

module complex_accum_dump #(
    parameter int IN_W    = 35,
    parameter int ACC_LEN = 16,
    parameter int SHIFT   = 4,
    parameter int OUT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_real,
    input  logic signed [IN_W-1:0]  in_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_real,
    output logic signed [OUT_W-1:0] out_imag,
    output logic                    sat_flag
);
    localparam int NUM_LANES = 2;
    localparam int CNT_W     = $clog2(ACC_LEN);
    localparam int ACC_W     = IN_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    logic [CNT_W-1:0]                  count;
    logic                              last;
    logic                              accept;
    logic                              dump;
    logic [NUM_LANES-1:0][IN_W-1:0]    din;
    logic [NUM_LANES-1:0][OUT_W-1:0]   res;
    logic [NUM_LANES-1:0]              sat;

    assign din[0]   = in_real;
    assign din[1]   = in_imag;
    assign last     = (count == LAST);
    // Only the block-closing sample can stall: it needs the output slot free.
    assign in_ready = !clear && !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign dump     = accept && last;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        complex_accum_dump_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W),
            .SHIFT (SHIFT),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .accept (accept),
            .last   (last),
            .din    (din[l]),
            .res    (res[l]),
            .sat    (sat[l])
        );
    end

    // Sample counter within the current block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || dump) begin
            count <= '0;
        end else if (accept) begin
            count <= count + CNT_W'(1);
        end
    end

    // Output slot: load on dump (even during a handshake), drop valid when taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            sat_flag  <= 1'b0;
        end else if (dump) begin
            out_valid <= 1'b1;
            out_real  <= res[0];
            out_imag  <= res[1];
            sat_flag  <= sat_flag | (|sat);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_complex_accum_dump.sv
// Bench for complex_accum_dump: directed vector table, handshake corner
// sequences, and a randomized run against a queue-based reference model.
module tb_complex_accum_dump;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: ACC_LEN=4, SHIFT=2, OUT_W=32
    logic               clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic               in_ready, out_valid, sat_flag;
    logic signed [34:0] in_real = '0, in_imag = '0;
    logic signed [31:0] out_real, out_imag;

    // narrow-output instance: OUT_W=8
    logic               s_clear = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
    logic               s_in_ready, s_out_valid, s_sat;
    logic signed [34:0] s_in_real = '0, s_in_imag = '0;
    logic signed [7:0]  s_out_real, s_out_imag;

    complex_accum_dump #(.IN_W(35), .ACC_LEN(4), .SHIFT(2), .OUT_W(32)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .sat_flag(sat_flag));

    complex_accum_dump #(.IN_W(35), .ACC_LEN(4), .SHIFT(2), .OUT_W(8)) u1 (
        .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_real(s_in_real), .in_imag(s_in_imag), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_real(s_out_real), .out_imag(s_out_imag), .sat_flag(s_sat));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Present one sample on u0 and hold it until accepted (bounded).
    task automatic send(input longint re, input longint im, output int w);
        w = 0;
        in_valid = 1'b1;
        in_real  = 35'(re);
        in_imag  = 35'(im);
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send4(input longint re, input longint im);
        int w;
        for (int k = 0; k < 4; k++) send(re, im, w);
    endtask

    typedef struct packed {
        logic signed [3:0][35:0] re;
        logic signed [3:0][35:0] im;
        logic signed [31:0]      er;
        logic signed [31:0]      ei;
        logic                    sat;
    } vec_t;

    function automatic vec_t mk(input longint r0, r1, r2, r3, i0, i1, i2, i3,
                                input longint er, ei, input logic s);
        vec_t v;
        v.re[0] = 36'(r0); v.re[1] = 36'(r1); v.re[2] = 36'(r2); v.re[3] = 36'(r3);
        v.im[0] = 36'(i0); v.im[1] = 36'(i1); v.im[2] = 36'(i2); v.im[3] = 36'(i3);
        v.er = 32'(er);
        v.ei = 32'(ei);
        v.sat = s;
        return v;
    endfunction

    // Reference for SHIFT=2, OUT_W=32: round half up, floor shift, clip.
    function automatic longint model_res(input longint s, output bit clip);
        longint maxv = 2147483647;
        longint minv = -maxv - 1;
        longint r = (s + 2) >>> 2;
        clip = 1'b0;
        if (r > maxv) begin clip = 1'b1; r = maxv; end
        else if (r < minv) begin clip = 1'b1; r = minv; end
        return r;
    endfunction

    function automatic longint rnd35();
        logic [63:0] t;
        if ($urandom_range(1) == 0) return longint'($urandom_range(2000)) - 1000;
        t = {$urandom(), $urandom()};
        return longint'($signed(t[34:0]));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t   tbl [10];
        int     w;
        longint p31 = 64'sd2147483648;
        longint p34 = 64'sd17179869184;
        longint bre[$], bim[$], ere[$], eim[$];
        bit     msat = 1'b0;
        bit     c0, c1;

        tbl[0] = mk(8, 8, 8, 8, -8, -8, -8, -8, 8, -8, 0);
        tbl[1] = mk(1, 1, 1, 3, 0, 0, 0, 0, 2, 0, 0);
        tbl[2] = mk(-1, -1, -1, -3, 0, 0, 0, 0, -1, 0, 0);
        tbl[3] = mk(2, 0, 0, 0, -2, 0, 0, 0, 1, 0, 0);
        tbl[4] = mk(-3, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0);
        tbl[5] = mk(5, 6, 7, -1, -5, -6, -7, 1, 4, -4, 0);
        tbl[6] = mk(p31-1, p31-1, p31-1, p31-1, -p31, -p31, -p31, -p31, p31-1, -p31, 0);
        tbl[7] = mk(p31, p31, p31, p31, 0, 0, 0, 0, p31-1, 0, 1);
        tbl[8] = mk(-p34, -p34, -p34, -p34, p34-1, p34-1, p34-1, p34-1, -p31, p31-1, 1);
        tbl[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_imag", out_imag, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_s_out_valid", s_out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // saturation on an 8-bit output, sticky across a later clean block
        for (int k = 0; k < 4; k++) begin
            s_in_valid = 1'b1;
            s_in_real  = 35'sd1073741824;
            @(negedge clk);
            chk("sat8_in_ready", s_in_ready, 1);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        chk("sat8_valid", s_out_valid, 1);
        chk("sat8_real", s_out_real, 127);
        chk("sat8_imag", s_out_imag, 0);
        chk("sat8_flag", s_sat, 1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            s_in_valid = 1'b1;
            s_in_real  = 35'sd1;
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        chk("sat8_small_real", s_out_real, 1);
        chk("sat8_sticky", s_sat, 1);

        // vector table
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++)
                send(longint'($signed(tbl[i].re[k])), longint'($signed(tbl[i].im[k])), w);
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_real", out_real, longint'(tbl[i].er));
            chk("tbl_imag", out_imag, longint'(tbl[i].ei));
            chk("tbl_sat", sat_flag, longint'(tbl[i].sat));
            @(posedge clk); #1;
            @(negedge clk);
            chk("tbl_valid_drop", out_valid, 0);
            @(posedge clk); #1;
        end

        // backpressure: two blocks against a stalled consumer
        out_ready = 1'b0;
        send4(4, 0);
        for (int k = 0; k < 3; k++) begin
            send(8, 0, w);
            chk("bp_nonfinal_wait", w, 0);
        end
        in_valid = 1'b1;
        in_real  = 35'sd8;
        in_imag  = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_real", out_real, 4);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", in_ready, 1);
        chk("bp_first_real", out_real, 4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_real", out_real, 8);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drained", out_valid, 0);
        @(posedge clk); #1;

        // clear discards a partial block and refuses the concurrent sample
        send(100, 0, w);
        send(100, 0, w);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_real  = 35'sd999;
        @(negedge clk);
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        send4(4, 0);
        @(negedge clk);
        chk("clr_valid", out_valid, 1);
        chk("clr_real", out_real, 4);
        @(posedge clk); #1;

        // async reset mid-block with a result pending
        out_ready = 1'b0;
        send4(4, 0);
        for (int k = 0; k < 3; k++) send(4, 0, w);
        chk("arst_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_real", out_real, 0);
        chk("arst_imag", out_imag, 0);
        chk("arst_sat", sat_flag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send4(4, 0);
        @(negedge clk);
        chk("arst_after_valid", out_valid, 1);
        chk("arst_after_real", out_real, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // randomized run against the queue model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_real   = 35'(rnd35());
            in_imag   = 35'(rnd35());
            out_ready = ($urandom_range(2) != 0);
            clear     = ($urandom_range(63) == 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (ere.size() == 0) chk("rand_spurious_out", 1, 0);
                else begin
                    chk("rand_real", out_real, ere.pop_front());
                    chk("rand_imag", out_imag, eim.pop_front());
                end
            end
            if (clear) begin
                chk("rand_clear_ready", in_ready, 0);
                bre.delete();
                bim.delete();
            end else begin
                if (bre.size() < 3) chk("rand_nonfinal_ready", in_ready, 1);
                if (in_valid && in_ready) begin
                    bre.push_back(longint'(in_real));
                    bim.push_back(longint'(in_imag));
                    if (bre.size() == 4) begin
                        ere.push_back(model_res(bre.sum(), c0));
                        eim.push_back(model_res(bim.sum(), c1));
                        msat = msat | c0 | c1;
                        bre.delete();
                        bim.delete();
                    end
                end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (ere.size() == 0) chk("drain_spurious_out", 1, 0);
                else begin
                    chk("drain_real", out_real, ere.pop_front());
                    chk("drain_imag", out_imag, eim.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        chk("rand_results_left", ere.size(), 0);
        chk("rand_sat_flag", sat_flag, longint'(msat));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
